// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared widths and master identifiers for the memory port arbiter.
// Contents: ADDR_W/DATA_W/BE_W bus widths, master_id_e (MID_INSTR=0, MID_DATA=1).
package mem_arb_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;
    typedef enum logic {MID_INSTR = 1'b0, MID_DATA = 1'b1} master_id_e;
endpackage

// File: rtl/mem_arb_id_fifo.sv
// mem_arb_id_fifo: in-order FIFO of master IDs for granted-but-unanswered transactions.
// Ports: clk/rst (sync, active-high); push+push_id enqueue; pop dequeues head;
//        count = occupancy, head = oldest outstanding ID.
module mem_arb_id_fifo
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  master_id_e    push_id,
    input  logic          pop,
    output logic [CW-1:0] count,
    output master_id_e    head
);
    master_id_e    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    assign head = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= MID_INSTR;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_id;
                wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one req/gnt/rvalid memory port between instruction and data masters.
// Ports: clk_i/rst_i (sync, active-high); instr_* and data_* master ports; mem_* slave port;
//        resp_err_o sticky flag for responses with nothing outstanding.
// Fixed data-over-instruction priority; responses routed back in issue order.
// Optional macro MEMARB_STARVE_GUARD_EN force-grants instr after STARVE_LIMIT refused cycles.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int STARVE_LIMIT    = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              instr_req_i,
    input  logic [ADDR_W-1:0] instr_addr_i,
    output logic              instr_gnt_o,
    output logic              instr_rvalid_o,
    output logic [DATA_W-1:0] instr_rdata_o,
    input  logic              data_req_i,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic              data_we_i,
    input  logic [BE_W-1:0]   data_be_i,
    input  logic [DATA_W-1:0] data_wdata_i,
    output logic              data_gnt_o,
    output logic              data_rvalid_o,
    output logic [DATA_W-1:0] data_rdata_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [BE_W-1:0]   mem_be_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              resp_err_o
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    logic [CW-1:0] count;
    master_id_e    head;
    logic          can_issue;
    logic          force_instr;
    logic          sel_data;
    logic          sel_instr;
    logic          push;
    logic          pop;
    // Uses the registered count only, so a same-cycle response never frees a slot early.
    assign can_issue   = count < CW'(MAX_OUTSTANDING);
    assign sel_data    = data_req_i & ~force_instr;
    assign sel_instr   = instr_req_i & ~sel_data;
    assign mem_req_o   = ~rst_i & can_issue & (instr_req_i | data_req_i);
    assign mem_addr_o  = sel_data ? data_addr_i  : instr_addr_i;
    assign mem_we_o    = sel_data ? data_we_i    : 1'b0;
    assign mem_be_o    = sel_data ? data_be_i    : {BE_W{1'b1}};
    assign mem_wdata_o = sel_data ? data_wdata_i : '0;
    assign push        = mem_req_o & mem_gnt_i;
    assign data_gnt_o  = push & sel_data;
    assign instr_gnt_o = push & sel_instr;
    assign pop            = ~rst_i & mem_rvalid_i & (count != '0);
    assign instr_rvalid_o = pop & (head == MID_INSTR);
    assign data_rvalid_o  = pop & (head == MID_DATA);
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;
    mem_arb_id_fifo #(.DEPTH(MAX_OUTSTANDING)) u_id_fifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .push    (push),
        .push_id (sel_data ? MID_DATA : MID_INSTR),
        .pop     (pop),
        .count   (count),
        .head    (head)
    );
    always_ff @(posedge clk_i) begin
        if (rst_i) resp_err_o <= 1'b0;
        else if (mem_rvalid_i && count == '0) resp_err_o <= 1'b1;
    end
`ifdef MEMARB_STARVE_GUARD_EN
    localparam int SW = ($clog2(STARVE_LIMIT + 1) > 4) ? $clog2(STARVE_LIMIT + 1) : 4;
    logic [SW-1:0] starve;
    assign force_instr = instr_req_i & (starve == SW'(STARVE_LIMIT));
    // Saturates at the limit so a stalled memory keeps the instr override asserted.
    always_ff @(posedge clk_i) begin
        if (rst_i || !instr_req_i || instr_gnt_o) starve <= '0;
        else if (can_issue && starve != SW'(STARVE_LIMIT)) starve <= starve + 1'b1;
    end
`else
    logic unused_starve_limit;
    assign unused_starve_limit = ^STARVE_LIMIT;
    assign force_instr = 1'b0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table plus ID scoreboard for mem_port_arbiter.
module tb_mem_port_arbiter;
    localparam logic [31:0] IADDR = 32'h0000_0200;
    localparam logic [31:0] DADDR = 32'h0000_1000;
    localparam logic [31:0] WD    = 32'hDEAD_BEEF;
    logic        clk = 0;
    logic        rst = 1;
    logic        instr_req = 0, data_req = 0, data_we = 0, mem_gnt = 0, mem_rvalid = 0;
    logic [3:0]  data_be = 4'hF;
    logic [31:0] mem_rdata = 0;
    logic        instr_gnt, instr_rvalid, data_gnt, data_rvalid;
    logic [31:0] instr_rdata, data_rdata, mem_addr, mem_wdata;
    logic        mem_req, mem_we, resp_err;
    logic [3:0]  mem_be;
    int          total = 0;
    int          bad = 0;
    bit          q[$];
    logic        merr = 0;
    typedef struct {
        logic ir, dr, we;
        logic [3:0] be;
        logic g, rv;
        logic [31:0] rd;
        logic emr, eig, edg, es;
    } vec_t;
    vec_t vt[11];
    always #5 clk = ~clk;
    mem_port_arbiter #(.MAX_OUTSTANDING(2), .STARVE_LIMIT(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .instr_req_i(instr_req), .instr_addr_i(IADDR), .instr_gnt_o(instr_gnt),
        .instr_rvalid_o(instr_rvalid), .instr_rdata_o(instr_rdata),
        .data_req_i(data_req), .data_addr_i(DADDR), .data_we_i(data_we), .data_be_i(data_be),
        .data_wdata_i(WD), .data_gnt_o(data_gnt), .data_rvalid_o(data_rvalid),
        .data_rdata_o(data_rdata),
        .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_be_o(mem_be),
        .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
        .mem_rdata_i(mem_rdata), .resp_err_o(resp_err)
    );
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic cyc(input logic ir, dr, we, input logic [3:0] be, input logic g, rv,
                       input logic [31:0] rd, input logic emr, eig, edg, es);
        bit   id;
        logic eirv = 0, edrv = 0;
        instr_req = ir; data_req = dr; data_we = we; data_be = be;
        mem_gnt = g; mem_rvalid = rv; mem_rdata = rd;
        #1;
        chk("mem_req", mem_req, emr);
        chk("instr_gnt", instr_gnt, eig);
        chk("data_gnt", data_gnt, edg);
        if (emr) begin
            chk("mem_addr", mem_addr, es ? DADDR : IADDR);
            chk("mem_we", mem_we, es ? we : 1'b0);
            chk("mem_be", mem_be, es ? be : 4'hF);
            chk("mem_wdata", mem_wdata, es ? WD : 32'h0);
        end
        if (rv) begin
            if (q.size() > 0) begin
                id = q.pop_front();
                eirv = !id;
                edrv = id;
            end else merr = 1;
        end
        chk("instr_rvalid", instr_rvalid, eirv);
        chk("data_rvalid", data_rvalid, edrv);
        chk("instr_rdata", instr_rdata, rd);
        chk("data_rdata", data_rdata, rd);
        if (eig) q.push_back(1'b0);
        if (edg) q.push_back(1'b1);
        @(posedge clk); #1;
        chk("resp_err", resp_err, merr);
    endtask
    task automatic do_reset(input logic ir, dr, rv);
        rst = 1; instr_req = ir; data_req = dr; mem_gnt = 1; mem_rvalid = rv;
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_instr_gnt", instr_gnt, 0);
        chk("rst_data_gnt", data_gnt, 0);
        chk("rst_instr_rvalid", instr_rvalid, 0);
        chk("rst_data_rvalid", data_rvalid, 0);
        @(posedge clk); #1;
        rst = 0; q.delete(); merr = 0;
        chk("rst_resp_err", resp_err, 0);
    endtask
    initial begin
        vt[0]  = '{1'b1, 1'b0, 1'b0, 4'hF, 1'b1, 1'b0, 32'h0,    1'b1, 1'b1, 1'b0, 1'b0};
        vt[1]  = '{1'b0, 1'b0, 1'b0, 4'hF, 1'b0, 1'b1, 32'h13,   1'b0, 1'b0, 1'b0, 1'b0};
        vt[2]  = '{1'b1, 1'b1, 1'b1, 4'h3, 1'b1, 1'b0, 32'h0,    1'b1, 1'b0, 1'b1, 1'b1};
        vt[3]  = '{1'b1, 1'b0, 1'b0, 4'hF, 1'b1, 1'b0, 32'h0,    1'b1, 1'b1, 1'b0, 1'b0};
        vt[4]  = '{1'b1, 1'b0, 1'b0, 4'hF, 1'b1, 1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 1'b0};
        vt[5]  = '{1'b1, 1'b0, 1'b0, 4'hF, 1'b1, 1'b1, 32'hA5A5, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[6]  = '{1'b1, 1'b0, 1'b0, 4'hF, 1'b1, 1'b1, 32'h5A,   1'b1, 1'b1, 1'b0, 1'b0};
        vt[7]  = '{1'b0, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 1'b0, 1'b1};
        vt[8]  = '{1'b0, 1'b1, 1'b0, 4'hF, 1'b1, 1'b1, 32'h77,   1'b1, 1'b0, 1'b1, 1'b1};
        vt[9]  = '{1'b0, 1'b0, 1'b0, 4'hF, 1'b0, 1'b1, 32'h88,   1'b0, 1'b0, 1'b0, 1'b0};
        vt[10] = '{1'b0, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 1'b0};
        do_reset(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 11; i++)
            cyc(vt[i].ir, vt[i].dr, vt[i].we, vt[i].be, vt[i].g, vt[i].rv, vt[i].rd,
                vt[i].emr, vt[i].eig, vt[i].edg, vt[i].es);
        chk("sb_empty_after_table", q.size(), 0);
        for (int n = 1; n <= 12; n++) begin
            logic forced = 0;
`ifdef MEMARB_STARVE_GUARD_EN
            forced = (n == 9);
`endif
            cyc(1'b1, 1'b1, 1'b0, 4'hF, 1'b1, n > 1, n, 1'b1, forced, !forced, !forced);
        end
        for (int k = 0; k < 4 && q.size() > 0; k++)
            cyc(1'b0, 1'b0, 1'b0, 4'hF, 1'b0, 1'b1, 32'h100 + k, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("sb_empty_after_starve", q.size(), 0);
        cyc(1'b1, 1'b0, 1'b0, 4'hF, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 4'hC, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        do_reset(1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 4'hF, 1'b0, 1'b1, 32'h55, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++)
            cyc(1'b0, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("err_sticky", resp_err, 1);
        do_reset(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port memory/peripheral bus (req/gnt/rvalid protocol) between the core instruction-fetch port and data port.
- Sits between riscv_core and memory_controller, so the memory controller needs only one master port.
- Fixed priority: data over instruction.
- Tracks outstanding transactions in order, so each rvalid is routed back to the master that issued it.

Parameters:
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered transactions (1..4).
- STARVE_LIMIT, 8, consecutive cycles instr_req may be refused before it is force-granted (optional feature only).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- instr_req_i  in  1  instruction request.
- instr_addr_i  in  32  instruction address.
- instr_gnt_o  out  1  instruction grant.
- instr_rvalid_o  out  1  instruction response valid.
- instr_rdata_o  out  32  instruction read data.
- data_req_i  in  1  data request.
- data_addr_i  in  32  data address.
- data_we_i  in  1  data write enable.
- data_be_i  in  4  data byte enables.
- data_wdata_i  in  32  data write data.
- data_gnt_o  out  1  data grant.
- data_rvalid_o  out  1  data response valid.
- data_rdata_o  out  32  data read data.
- mem_req_o  out  1  request to memory.
- mem_addr_o  out  32  address to memory.
- mem_we_o  out  1  write enable to memory.
- mem_be_o  out  4  byte enables to memory.
- mem_wdata_o  out  32  write data to memory.
- mem_gnt_i  in  1  memory grant.
- mem_rvalid_i  in  1  memory response valid.
- mem_rdata_i  in  32  memory read data.
- resp_err_o  out  1  sticky: rvalid arrived with no outstanding transaction.

Behaviour:
- Clocking and reset: single clock, clk_i. rst_i is synchronous and active-high; all state is cleared on the rising edge of clk_i while rst_i=1.
- Selection (combinational): sel_data = data_req_i; otherwise sel_instr = instr_req_i. Optional feature may override.
- Outstanding tracking: ID FIFO of depth MAX_OUTSTANDING, 1 bit per entry (0=instr, 1=data), plus a registered count.
- can_issue = (count < MAX_OUTSTANDING). It uses the registered count only; a pop in the same cycle does not free a slot for a grant in that cycle.
- mem_req_o = can_issue & (instr_req_i | data_req_i). Address, we, be and wdata are muxed from the selected master.
- Instruction request is muxed with we=0, be=4'hF, wdata=0.
- Grants: data_gnt_o = mem_gnt_i & mem_req_o & sel_data; instr_gnt_o likewise for sel_instr. Grants are combinational, zero-latency pass-through.
- Push: on a cycle where mem_req_o & mem_gnt_i, the selected ID is pushed.
- Response routing: on mem_rvalid_i with count>0, the head ID is popped and the matching *_rvalid_o is asserted in the same cycle (combinational).
- Read data: mem_rdata_i drives both instr_rdata_o and data_rdata_o unconditionally.
- Simultaneous push and pop in one cycle: count is unchanged, pointers both advance; legal, including at full.
- Spurious response: mem_rvalid_i with count==0 → no rvalid to either master, resp_err_o set to 1 until reset.
- Master protocol: a master holds req/addr stable until granted; the arbiter does not require this to be correct.
- Reset values:
  - count=0, pointers=0, resp_err_o=0.
  - While rst_i=1: mem_req_o, both gnt and both rvalid outputs forced 0.
- Reset mid-operation: in-flight IDs are discarded. Late responses after reset count as spurious and set resp_err_o.
- Latency: arbitration adds 0 cycles to grant and to response.

Optional Feature:
- Macro: MEMARB_STARVE_GUARD_EN.
- With the macro: a 4-bit-or-wider starve counter increments each cycle instr_req_i=1 & can_issue & instr not granted, and clears on instr grant or when instr_req_i=0.
  - When counter == STARVE_LIMIT, instr is selected over data for that cycle.
  - The counter clears on that grant.
  - The counter is reset to 0 by rst_i.
- Without the macro: pure fixed data priority; instr may starve indefinitely.

Decomposition:
- Shared package mem_arb_pkg holds:
  - typedef master_id_e {MID_INSTR=1'b0, MID_DATA=1'b1};
  - localparam ADDR_W=32, DATA_W=32, BE_W=4.
- One sub-module: mem_arb_id_fifo (parameterised depth, push/pop/count/head, synchronous active-high reset).

Test Plan:
- Lone requests: instr_req=1, addr=0x200, mem_gnt=1, rvalid 1 cycle later with rdata=0x00000013 → instr_gnt=1, then instr_rvalid=1 with rdata 0x13, data_rvalid=0.
- Contention: instr_req and data_req both 1, data write addr=0x1000 be=4'h3 → data_gnt first, mem_we=1, mem_be=4'h3; instr granted the next cycle.
- Full: MAX_OUTSTANDING=2, two granted, no rvalid → mem_req_o=0 on the 3rd request. rvalid in the same cycle still blocks that cycle; grant the cycle after.
- Ordering: issue instr then data with in-order rvalids → instr_rvalid then data_rvalid exactly once each, count returns to 0.
- Spurious response: mem_rvalid_i=1 with count=0 → no rvalid out, resp_err_o=1 and sticky until rst_i. Also assert rst_i with 2 outstanding → count=0 next cycle.
- Starvation, with MEMARB_STARVE_GUARD_EN and STARVE_LIMIT=8: data_req held at 1, instr_req=1 → instr_gnt asserted on the 9th request cycle. Without the macro → never asserted.
